cmp_branch_unit: RTL and testbench
==================================

# cmp_branch_unit

Registered, parametrised compare-and-branch unit for the Harvard Architecture Processor execute stage. It evaluates unsigned and signed compares plus conditional and unconditional branches on WIDTH-bit operands. It holds a sticky compare flag for flag-based branches, computes the branch target, and squashes a configurable number of shadow operations after a taken branch. Operations enter and leave through valid/ready handshakes with one cycle of latency.

## Interface
- WIDTH, 8: operand and result width; must be at least 2.
- PC_W, 8: program-counter and target width.
- SHADOW, 1: number of accepted operations squashed after a taken branch; legal range 0..7.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept; in_ready = !out_valid || out_ready.
- mode  in  4  operation select (see Operation).
- R1  in  WIDTH  first operand.
- R2  in  WIDTH  second operand.
- imm  in  PC_W  branch offset, two's complement.
- pc  in  PC_W  address of the operation.
- out_valid  out  1  result register holds an operation.
- out_ready  in  1  consumer takes the result.
- out  out  WIDTH  bit0 = condition; bits WIDTH-1:1 are always 0.
- taken  out  1  branch taken; 0 for compares, squashed operations and reserved modes.
- target  out  PC_W  branch target; 0 when taken = 0.
- squashed  out  1  operation was squashed as a branch shadow.
- err  out  1  reserved mode was accepted.
- flag  out  1  current sticky compare flag.

## Operation
- Accept occurs when in_valid && in_ready. Only an accepted operation updates the output register, flag or shadow counter.
- Unsigned compares write the result to flag and to out[0], with taken = 0:
  - 0 LT, 1 GT, 2 EQ, 3 GTE, 4 LTE, 5 NE.
- Signed compares, two's complement over WIDTH bits, also write flag and out[0], with taken = 0:
  - 6 SLT, 7 SGT.
- Branches leave flag unchanged. out[0] = condition; taken = condition.
  - 8 BEZ: condition R1 == 0.
  - 9 BNZ: condition R1 != 0.
  - 10 BT: condition flag.
  - 11 BF: condition !flag.
  - 12 J: condition always 1.
  - 13 JR: condition always 1; target = R1 zero-extended or truncated to PC_W.
- Branch target for modes 8–12: target = pc + imm, mod 2^PC_W. Wrap-around is silent.
- Modes 14 and 15 are reserved: out = 0, taken = 0, err = 1, flag unchanged. Reserved modes do not start a shadow.
- BT/BF read the flag value before the current edge. A compare accepted in cycle n is therefore visible to a BT/BF accepted in cycle n+1 or later.
- Shadow counter sc:
  - A taken branch accepted while sc == 0 loads sc = SHADOW.
  - Each accepted operation while sc > 0 decrements sc and is squashed: squashed = 1, out = 0, taken = 0, err = 0.
  - A squashed operation does not write flag and cannot start a new shadow.
- SHADOW = 0: squashing never occurs.

## Timing
- Reset: out_valid 0, out 0, taken 0, target 0, squashed 0, err 0, flag 0, sc 0. in_ready = 1 in the cycle after reset.
- Reset asserted mid-operation discards any held result and any pending shadow in that same edge. in_valid is ignored while rst = 1.
- Latency: an operation accepted at edge n appears with out_valid = 1 after edge n. All outputs are registered.
- Hold: while out_valid && !out_ready, every output is stable, in_ready = 0 and flag is frozen.
- Drain and accept in the same edge is allowed, giving one operation per cycle sustained throughput.
- out_valid falls after an edge with out_ready && !in_valid while out_valid = 1.
- The flag output updates on the same edge as out_valid for the writing compare.

## Test plan
- Reset: hold rst 2 cycles with in_valid = 1 -> all outputs 0, flag 0, in_ready 1, nothing accepted.
- Compares, WIDTH=8:
  - LT with R1=3, R2=200 -> out=1, flag=1.
  - SLT with R1=8'h80, R2=8'h01 -> out=1.
  - SGT on the same operands -> out=0, flag=0.
  - GTE with R1=R2=8'h5A -> out=1.
- Flag forwarding: EQ (7,7) then BT at pc=8'hF0, imm=8'h20 on consecutive cycles -> BT taken=1, target=8'h10 (wrap).
  - Same sequence with BF -> taken=0, target=0.
- Shadow, SHADOW=1: J, then LT (1,2), then BEZ with R1=0 -> LT squashed=1, out=0, flag unchanged. BEZ taken=1 and starts a new shadow.
- Backpressure: out_ready=0 for 3 cycles with a new op offered -> in_ready=0, outputs and flag stable. Releasing out_ready accepts the new op on that edge.
- Reserved mode 15, then JR with R1=8'h3C -> err=1, taken=0 first. Then taken=1, target=8'h3C, not squashed.

Source files
------------

// File: rtl/cmp_branch_if.sv
// Handshake and operand bundle for the compare-and-branch unit.
// The execute-stage driver uses the master modport. The unit uses the slave modport.
interface cmp_branch_if #(
  parameter int WIDTH = 8,
  parameter int PC_W  = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       mode;
  logic [WIDTH-1:0] R1;
  logic [WIDTH-1:0] R2;
  logic [PC_W-1:0]  imm;
  logic [PC_W-1:0]  pc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             taken;
  logic [PC_W-1:0]  target;
  logic             squashed;
  logic             err;
  logic             flag;

  modport master (
    output in_valid, mode, R1, R2, imm, pc, out_ready,
    input  in_ready, out_valid, out, taken, target, squashed, err, flag
  );

  modport slave (
    input  in_valid, mode, R1, R2, imm, pc, out_ready,
    output in_ready, out_valid, out, taken, target, squashed, err, flag
  );
endinterface

// File: rtl/cmp_branch_unit.sv
// Registered compare-and-branch unit with a sticky compare flag and
// branch-shadow squashing. The unit has one result register and a
// valid/ready handshake. Latency is one cycle.
module cmp_branch_unit #(
  parameter int WIDTH  = 8,
  parameter int PC_W   = 8,
  parameter int SHADOW = 1
) (
  input logic          clk,
  input logic          rst,
  cmp_branch_if.slave  bus
);

  localparam logic [3:0] MODE_LT  = 4'd0;
  localparam logic [3:0] MODE_GT  = 4'd1;
  localparam logic [3:0] MODE_EQ  = 4'd2;
  localparam logic [3:0] MODE_GTE = 4'd3;
  localparam logic [3:0] MODE_LTE = 4'd4;
  localparam logic [3:0] MODE_NE  = 4'd5;
  localparam logic [3:0] MODE_SLT = 4'd6;
  localparam logic [3:0] MODE_SGT = 4'd7;
  localparam logic [3:0] MODE_BEZ = 4'd8;
  localparam logic [3:0] MODE_BNZ = 4'd9;
  localparam logic [3:0] MODE_BT  = 4'd10;
  localparam logic [3:0] MODE_BF  = 4'd11;
  localparam logic [3:0] MODE_J   = 4'd12;
  localparam logic [3:0] MODE_JR  = 4'd13;

  localparam logic [2:0] SC_LOAD = 3'(SHADOW);

  // Result and state registers
  logic            out_valid_reg, out_valid_next;
  logic            cond_reg,      cond_next;
  logic            taken_reg,     taken_next;
  logic [PC_W-1:0] target_reg,    target_next;
  logic            squashed_reg,  squashed_next;
  logic            err_reg,       err_next;
  logic            flag_reg,      flag_next;
  logic [2:0]      sc_reg,        sc_next;

  logic            accept;
  logic            is_cmp;
  logic            is_br;
  logic            cmp_res;
  logic            br_cond;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] jr_tgt;

  assign bus.in_ready = !out_valid_reg || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // The top bit of mode separates compares from branches and reserved codes.
  assign is_cmp = (bus.mode[3] == 1'b0);
  assign is_br  = (bus.mode >= MODE_BEZ) && (bus.mode <= MODE_JR);

  // The relative target wraps modulo 2^PC_W.
  assign br_tgt = bus.pc + bus.imm;

  // The JR target is R1, zero-extended or truncated to PC_W bits.
  generate
    for (genvar gi = 0; gi < PC_W; gi++) begin : g_jr_tgt
      if (gi < WIDTH) begin : g_bit
        assign jr_tgt[gi] = bus.R1[gi];
      end else begin : g_zero
        assign jr_tgt[gi] = 1'b0;
      end
    end
  endgenerate

  // Compare result for modes 0..7. Signed compares use two's complement.
  always_comb begin
    cmp_res = 1'b0;
    case (bus.mode)
      MODE_LT:  cmp_res = bus.R1 <  bus.R2;
      MODE_GT:  cmp_res = bus.R1 >  bus.R2;
      MODE_EQ:  cmp_res = bus.R1 == bus.R2;
      MODE_GTE: cmp_res = bus.R1 >= bus.R2;
      MODE_LTE: cmp_res = bus.R1 <= bus.R2;
      MODE_NE:  cmp_res = bus.R1 != bus.R2;
      MODE_SLT: cmp_res = $signed(bus.R1) < $signed(bus.R2);
      MODE_SGT: cmp_res = $signed(bus.R1) > $signed(bus.R2);
      default:  cmp_res = 1'b0;
    endcase
  end

  // Branch condition for modes 8..13. BT and BF read the registered flag,
  // so they see any compare that was accepted in an earlier cycle.
  always_comb begin
    br_cond = 1'b0;
    case (bus.mode)
      MODE_BEZ: br_cond = (bus.R1 == '0);
      MODE_BNZ: br_cond = (bus.R1 != '0);
      MODE_BT:  br_cond = flag_reg;
      MODE_BF:  br_cond = !flag_reg;
      MODE_J:   br_cond = 1'b1;
      MODE_JR:  br_cond = 1'b1;
      default:  br_cond = 1'b0;
    endcase
  end

  // Next-state logic: drain the result, accept a new operation, apply the shadow.
  always_comb begin
    out_valid_next = out_valid_reg;
    cond_next      = cond_reg;
    taken_next     = taken_reg;
    target_next    = target_reg;
    squashed_next  = squashed_reg;
    err_next       = err_reg;
    flag_next      = flag_reg;
    sc_next        = sc_reg;

    if (out_valid_reg && bus.out_ready) begin
      out_valid_next = 1'b0;
    end

    if (accept) begin
      out_valid_next = 1'b1;
      cond_next      = 1'b0;
      taken_next     = 1'b0;
      target_next    = '0;
      squashed_next  = 1'b0;
      err_next       = 1'b0;
      if (sc_reg != 3'd0) begin
        // A shadow operation has no side effects. It only counts down the shadow.
        squashed_next = 1'b1;
        sc_next       = sc_reg - 3'd1;
      end else if (is_cmp) begin
        cond_next = cmp_res;
        flag_next = cmp_res;
      end else if (is_br) begin
        cond_next  = br_cond;
        taken_next = br_cond;
        if (br_cond) begin
          target_next = (bus.mode == MODE_JR) ? jr_tgt : br_tgt;
          sc_next     = SC_LOAD;
        end
      end else begin
        err_next = 1'b1;
      end
    end
  end

  // State register. A reset discards the held result and any pending shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      cond_reg      <= 1'b0;
      taken_reg     <= 1'b0;
      target_reg    <= '0;
      squashed_reg  <= 1'b0;
      err_reg       <= 1'b0;
      flag_reg      <= 1'b0;
      sc_reg        <= 3'd0;
    end else begin
      out_valid_reg <= out_valid_next;
      cond_reg      <= cond_next;
      taken_reg     <= taken_next;
      target_reg    <= target_next;
      squashed_reg  <= squashed_next;
      err_reg       <= err_next;
      flag_reg      <= flag_next;
      sc_reg        <= sc_next;
    end
  end

  // Only bit 0 of the result carries the condition. The upper bits are tied to 0.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_out
      if (gi == 0) begin : g_cond
        assign bus.out[gi] = cond_reg;
      end else begin : g_zero
        assign bus.out[gi] = 1'b0;
      end
    end
  endgenerate

  assign bus.out_valid = out_valid_reg;
  assign bus.taken     = taken_reg;
  assign bus.target    = target_reg;
  assign bus.squashed  = squashed_reg;
  assign bus.err       = err_reg;
  assign bus.flag      = flag_reg;

endmodule

// File: tb/tb_cmp_branch_unit.sv
// Directed testbench for cmp_branch_unit (WIDTH=8, PC_W=8, SHADOW=1).
module tb_cmp_branch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  always #5 clk = ~clk;

  cmp_branch_if #(.WIDTH(8), .PC_W(8)) bus ();

  cmp_branch_unit #(.WIDTH(8), .PC_W(8), .SHADOW(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] mode;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [7:0] imm;
    logic [7:0] pc;
    logic       cond;
    logic       taken;
    logic [7:0] target;
    logic       sq;
    logic       err;
    logic       flag;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Packs the visible outputs as {out, taken, target, squashed, err, flag, out_valid}.
  function automatic logic [31:0] snap();
    return {11'd0, bus.out, bus.taken, bus.target, bus.squashed, bus.err, bus.flag, bus.out_valid};
  endfunction

  function automatic logic [31:0] expv(input logic c, input logic t, input logic [7:0] tg,
                                       input logic s, input logic e, input logic f, input logic v);
    return {11'd0, 7'd0, c, t, tg, s, e, f, v};
  endfunction

  // Presents one operation with out_ready=1 and checks the result after the edge.
  task automatic run_op(input string name, input vec_t v);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    bus.mode = v.mode; bus.R1 = v.r1; bus.R2 = v.r2; bus.imm = v.imm; bus.pc = v.pc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check(name, snap(), expv(v.cond, v.taken, v.target, v.sq, v.err, v.flag, 1'b1));
  endtask

  initial begin
    vec_t tmp;
    //           mode   r1     r2     imm    pc     c  t  target s  e  f
    vecs[0]  = '{4'd0,  8'd3,  8'd200,8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 1}; // LT
    vecs[1]  = '{4'd6,  8'h80, 8'h01, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 1}; // SLT
    vecs[2]  = '{4'd7,  8'h80, 8'h01, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0}; // SGT
    vecs[3]  = '{4'd3,  8'h5A, 8'h5A, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 1}; // GTE
    vecs[4]  = '{4'd2,  8'd7,  8'd7,  8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 1}; // EQ
    vecs[5]  = '{4'd10, 8'd0,  8'd0,  8'h20, 8'hF0, 1, 1, 8'h10, 0, 0, 1}; // BT wraps
    vecs[6]  = '{4'd0,  8'd1,  8'd2,  8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 1}; // shadow
    vecs[7]  = '{4'd2,  8'd7,  8'd7,  8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 1}; // EQ
    vecs[8]  = '{4'd11, 8'd0,  8'd0,  8'h20, 8'hF0, 0, 0, 8'h00, 0, 0, 1}; // BF
    vecs[9]  = '{4'd12, 8'd0,  8'd0,  8'hFE, 8'h10, 1, 1, 8'h0E, 0, 0, 1}; // J
    vecs[10] = '{4'd0,  8'd1,  8'd2,  8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 1}; // shadow
    vecs[11] = '{4'd8,  8'd0,  8'd9,  8'h04, 8'h40, 1, 1, 8'h44, 0, 0, 1}; // BEZ
    vecs[12] = '{4'd5,  8'd3,  8'd3,  8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 1}; // shadow
    vecs[13] = '{4'd15, 8'd1,  8'd2,  8'h11, 8'h22, 0, 0, 8'h00, 0, 1, 1}; // reserved
    vecs[14] = '{4'd13, 8'h3C, 8'd0,  8'h55, 8'h00, 1, 1, 8'h3C, 0, 0, 1}; // JR
    vecs[15] = '{4'd1,  8'd5,  8'd4,  8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 1}; // shadow
    vecs[16] = '{4'd9,  8'd0,  8'd0,  8'h10, 8'h20, 0, 0, 8'h00, 0, 0, 1}; // BNZ not
    vecs[17] = '{4'd4,  8'd4,  8'd4,  8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 1}; // LTE
    vecs[18] = '{4'd6,  8'h7F, 8'hFF, 8'h00, 8'h00, 0, 0, 8'h00, 0, 0, 0}; // SLT 127<-1
    vecs[19] = '{4'd10, 8'd0,  8'd0,  8'h08, 8'h30, 0, 0, 8'h00, 0, 0, 0}; // BT not
    vecs[20] = '{4'd11, 8'd0,  8'd0,  8'h80, 8'h00, 1, 1, 8'h80, 0, 0, 0}; // BF taken
    vecs[21] = '{4'd14, 8'd0,  8'd0,  8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 0}; // reserved in shadow
    vecs[22] = '{4'd9,  8'd5,  8'd0,  8'h01, 8'hFF, 1, 1, 8'h00, 0, 0, 0}; // BNZ wrap to 0
    vecs[23] = '{4'd0,  8'd9,  8'd9,  8'h00, 8'h00, 0, 0, 8'h00, 1, 0, 0}; // shadow

    // Reset is held for 2 cycles with in_valid high. Nothing may be accepted.
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    bus.mode = 4'd0; bus.R1 = 8'd3; bus.R2 = 8'd200; bus.imm = 8'h00; bus.pc = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", snap(), 32'd0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset_idle", snap(), 32'd0);

    // Back-to-back table vectors.
    for (int i = 0; i < NVEC; i++) begin
      run_op($sformatf("vec%0d_mode%0d", i, vecs[i].mode), vecs[i]);
    end

    // Backpressure: the held LT result must stay stable while a new op waits.
    tmp = '{4'd0, 8'd3, 8'd200, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 1};
    run_op("bp_first", tmp);
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.mode = 4'd2; bus.R1 = 8'd1; bus.R2 = 8'd2;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp_hold%0d", c), snap(), expv(1, 0, 8'h00, 0, 0, 1, 1));
      check($sformatf("bp_in_ready%0d", c), {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_accept", snap(), expv(0, 0, 8'h00, 0, 0, 0, 1));
    @(posedge clk); #1;
    check("drain", snap(), expv(0, 0, 8'h00, 0, 0, 0, 0));

    // A reset in mid-shadow must clear the pending shadow and the flag.
    tmp = '{4'd12, 8'd0, 8'd0, 8'h02, 8'h04, 1, 1, 8'h06, 0, 0, 0};
    run_op("pre_rst_j", tmp);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst", snap(), 32'd0);
    tmp = '{4'd0, 8'd1, 8'd2, 8'h00, 8'h00, 1, 0, 8'h00, 0, 0, 1};
    run_op("post_rst_not_squashed", tmp);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
